// File: rtl/aes_decipher_block_par.sv
// aes_decipher_block_par: iterative AES-128/AES-256 inverse cipher, one 128-bit
// block per command. The block drives the round index it needs and the key
// memory answers with the matching round key in the same cycle. SBOX_WORDS
// inverse S-box lanes (32 bits each) trade area against latency.
module aes_decipher_block_par #(
  parameter int SBOX_WORDS = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  input  logic [127:0] block,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [127:0] new_block,
  output logic         ready
);

  if (!(SBOX_WORDS == 1 || SBOX_WORDS == 2 || SBOX_WORDS == 4)) begin : g_bad_param
    $error("SBOX_WORDS must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_SBOX  = 2'd2,
    ST_ROUND = 2'd3
  } fsm_t;

  // GF(2^8) multiply by x, reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Generic GF(2^8) multiply (shift-and-add).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = b[i] ? (p ^ aa) : p;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
    return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
  endfunction

  // Row r of the column-major state rotates right by r byte positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    return {s[127:120], s[23:16],   s[47:40],   s[71:64],
            s[95:88],   s[119:112], s[15:8],    s[39:32],
            s[63:56],   s[87:80],   s[111:104], s[7:0],
            s[31:24],   s[55:48],   s[79:72],   s[103:96]};
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_column(s[127:96]), inv_mix_column(s[95:64]),
            inv_mix_column(s[63:32]),  inv_mix_column(s[31:0])};
  endfunction

  fsm_t                      fsm_r, fsm_nxt_s;
  logic [3:0]                round_r, round_nxt_s;
  logic                      ready_r, ready_nxt_s;
  logic [127:0]              state_r, state_nxt_s;
  logic [1:0]                ctr_r, ctr_nxt_s;
  logic [2:0]                ctr_sum_s;
  logic [127:0]              sub_state_s;
  logic [127:0]              addk_s;
  logic [2*SBOX_WORDS-1:0]   lane_idx_s;
  logic [32*SBOX_WORDS-1:0]  lane_in_s;
  logic [32*SBOX_WORDS-1:0]  lane_out_s;

  // The carry out of the 3-bit sum marks the last substitution cycle of a round.
  assign ctr_sum_s = {1'b0, ctr_r} + 3'(SBOX_WORDS);
  assign addk_s    = inv_shift_rows(state_r) ^ round_key;

  for (genvar l = 0; l < SBOX_WORDS; l++) begin : g_lane
    // Lane l substitutes word (sword_ctr + l); word 0 sits in bits [127:96].
    assign lane_idx_s[2*l +: 2]  = ctr_r + 2'(l);
    assign lane_in_s[32*l +: 32] = state_r[{2'd3 - lane_idx_s[2*l +: 2], 5'd0} +: 32];
    assign lane_out_s[32*l +: 32] = inv_sub_word(lane_in_s[32*l +: 32]);
  end

  // Write the substituted lane words back into their positions of the state.
  always_comb begin
    sub_state_s = state_r;
    for (int l = 0; l < SBOX_WORDS; l++) begin
      sub_state_s[{2'd3 - lane_idx_s[2*l +: 2], 5'd0} +: 32] = lane_out_s[32*l +: 32];
    end
  end

  // Next-state and datapath selection for the IDLE/INIT/SBOX/ROUND sequence.
  always_comb begin
    fsm_nxt_s   = fsm_r;
    round_nxt_s = round_r;
    ready_nxt_s = ready_r;
    state_nxt_s = state_r;
    ctr_nxt_s   = ctr_r;
    case (fsm_r)
      ST_IDLE: begin
        if (next) begin
          state_nxt_s = block;
          round_nxt_s = keylen ? 4'd14 : 4'd10;
          ready_nxt_s = 1'b0;
          fsm_nxt_s   = ST_INIT;
        end else begin
          ready_nxt_s = 1'b1;
        end
      end
      ST_INIT: begin
        state_nxt_s = state_r ^ round_key;
        round_nxt_s = round_r - 4'd1;
        ctr_nxt_s   = 2'd0;
        fsm_nxt_s   = ST_SBOX;
      end
      ST_SBOX: begin
        state_nxt_s = sub_state_s;
        ctr_nxt_s   = ctr_sum_s[1:0];
        if (ctr_sum_s[2]) begin
          fsm_nxt_s = ST_ROUND;
        end else begin
          fsm_nxt_s = ST_SBOX;
        end
      end
      ST_ROUND: begin
        if (round_r != 4'd0) begin
          state_nxt_s = inv_mix_columns(addk_s);
          round_nxt_s = round_r - 4'd1;
          fsm_nxt_s   = ST_SBOX;
        end else begin
          // Final round carries no InvMixColumns.
          state_nxt_s = addk_s;
          ready_nxt_s = 1'b1;
          fsm_nxt_s   = ST_IDLE;
        end
      end
      default: begin
        fsm_nxt_s   = ST_IDLE;
        round_nxt_s = 4'd0;
        ready_nxt_s = 1'b1;
        ctr_nxt_s   = 2'd0;
      end
    endcase
  end

  // State, round index and handshake registers; reset aborts any operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_r   <= ST_IDLE;
      round_r <= 4'd0;
      ready_r <= 1'b1;
      state_r <= 128'h0;
      ctr_r   <= 2'd0;
    end else begin
      fsm_r   <= fsm_nxt_s;
      round_r <= round_nxt_s;
      ready_r <= ready_nxt_s;
      state_r <= state_nxt_s;
      ctr_r   <= ctr_nxt_s;
    end
  end

  assign round     = round_r;
  assign new_block = state_r;
  assign ready     = ready_r;

endmodule

// File: tb/tb_aes_decipher_block_par.sv
// Testbench for aes_decipher_block_par: three instances (SBOX_WORDS 1, 2, 4),
// each with its own key memory, stimulus process and scoreboard monitor.
module tb_aes_decipher_block_par;

  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           acc;
    int           nr;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   tables_ready = 1'b0;
  bit   lane_done [3];
  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input int sw, input string nm, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL sbox_words=%0d %s: got %h expected %h", sw, nm, got, expv);
    end
  endtask

  // ---------------- reference model (FIPS-197 definitions) ----------------
  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = m_xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_rotl(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [31:0] m_sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] round_key_of(input logic [255:0] key, input bit k256, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nw;
    nk = k256 ? 8 : 4;
    nw = 4 * ((k256 ? 14 : 10) + 1);
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = m_sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = m_xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = m_sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] m_inv_shift(input logic [127:0] s);
    logic [127:0] y;
    y = s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        y[127 - 8*(4*((c + r) % 4) + r) -: 8] = s[127 - 8*(4*c + r) -: 8];
    return y;
  endfunction

  function automatic logic [127:0] m_inv_sub(input logic [127:0] s);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = isbox_t[s[8*i +: 8]];
    return y;
  endfunction

  function automatic logic [127:0] m_inv_mix(input logic [127:0] s);
    logic [127:0] y;
    logic [7:0] coef [4];
    logic [7:0] a [4];
    logic [7:0] b;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 8*(4*c + j) -: 8];
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ m_mul(coef[(j - r + 4) % 4], a[j]);
        y[127 - 8*(4*c + r) -: 8] = b;
      end
    end
    return y;
  endfunction

  function automatic logic [127:0] m_decrypt(input logic [127:0] ct, input logic [255:0] key, input bit k256);
    logic [127:0] s;
    int nr;
    nr = k256 ? 14 : 10;
    s = ct ^ round_key_of(key, k256, nr);
    for (int r = nr - 1; r >= 0; r--) begin
      s = m_inv_sub(m_inv_shift(s)) ^ round_key_of(key, k256, r);
      if (r > 0) s = m_inv_mix(s);
    end
    return s;
  endfunction

  // ---------------- one DUT per S-box lane count ----------------
  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int SW = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    localparam int S  = 4 / SW;

    logic         rst_n_l;
    logic         next_l;
    logic         keylen_l;
    logic         ready_l;
    logic [127:0] block_l;
    logic [127:0] round_key_l;
    logic [127:0] new_block_l;
    logic [3:0]   round_l;
    logic [127:0] kmem [16];
    exp_t         q [$];
    exp_t         e;
    bit           prev_ready = 1'b1;
    bit           ign_rise = 1'b0;
    bit           round_bad = 1'b0;
    int           d;
    int           er;

    // Key memory: combinational lookup of the requested round key.
    assign round_key_l = kmem[round_l];

    aes_decipher_block_par #(.SBOX_WORDS(SW)) dut (
      .clk      (clk),
      .reset_n  (rst_n_l),
      .next     (next_l),
      .keylen   (keylen_l),
      .block    (block_l),
      .round    (round_l),
      .round_key(round_key_l),
      .new_block(new_block_l),
      .ready    (ready_l)
    );

    // Monitor: track the round sequence while busy, score each completion.
    always @(negedge clk) begin
      if (ready_l === 1'b0 && q.size() > 0) begin
        d  = cyc - q[0].acc;
        er = (d <= 0) ? q[0].nr : q[0].nr - 1 - (d - 1) / (S + 1);
        if (int'(round_l) != er) round_bad = 1'b1;
      end
      if (ready_l === 1'b1 && !prev_ready) begin
        if (ign_rise) begin
          ign_rise = 1'b0;
        end else if (q.size() == 0) begin
          check_val(SW, "unexpected_done", 128'h1, 128'h0);
        end else begin
          e = q.pop_front();
          check_val(SW, "plaintext", new_block_l, e.pt);
          check_val(SW, "latency", 128'(cyc - e.acc), 128'(e.lat));
          check_val(SW, "round_sequence", {127'h0, round_bad}, 128'h0);
          check_val(SW, "round_idle", {124'h0, round_l}, 128'h0);
          round_bad = 1'b0;
        end
      end
      prev_ready = (ready_l === 1'b1);
    end

    task automatic load_keys(input logic [255:0] key, input bit k256);
      for (int r = 0; r < 16; r++)
        kmem[r] = (r <= (k256 ? 14 : 10)) ? round_key_of(key, k256, r) : 128'h0;
    endtask

    task automatic wait_ready(input string nm);
      int n;
      n = 0;
      while (ready_l !== 1'b1 && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (ready_l !== 1'b1) check_val(SW, {nm, "_timeout"}, {127'h0, ready_l}, 128'h1);
    endtask

    task automatic issue(input logic [127:0] ct, input logic [255:0] key, input bit k256, input logic [127:0] pt);
      int nr;
      nr = k256 ? 14 : 10;
      wait_ready("idle");
      load_keys(key, k256);
      block_l  = ct;
      keylen_l = k256;
      next_l   = 1'b1;
      q.push_back('{pt, 1 + nr * (S + 1), cyc + 1, nr});
      @(negedge clk);
      next_l   = 1'b0;
      block_l  = {$urandom(), $urandom(), $urandom(), $urandom()};
      keylen_l = 1'($urandom_range(0, 1));
      check_val(SW, "busy_after_accept", {127'h0, ready_l}, 128'h0);
    endtask

    // Stimulus for this instance.
    initial begin
      logic [255:0] key;
      logic [127:0] ct;
      bit           k;
      rst_n_l  = 1'b0;
      next_l   = 1'b0;
      keylen_l = 1'b0;
      block_l  = 128'h0;
      for (int r = 0; r < 16; r++) kmem[r] = 128'h0;
      wait (tables_ready);
      @(negedge clk);
      @(negedge clk);
      check_val(SW, "reset_ready", {127'h0, ready_l}, 128'h1);
      check_val(SW, "reset_new_block", new_block_l, 128'h0);
      check_val(SW, "reset_round", {124'h0, round_l}, 128'h0);
      rst_n_l = 1'b1;
      @(negedge clk);

      issue(CT1, KEY1, 1'b0, PT);
      wait_ready("c1");
      issue(CT3, KEY3, 1'b1, PT);
      wait_ready("c3");

      // next pulsed mid-run with a different block must be ignored
      issue(CT1, KEY1, 1'b0, PT);
      repeat (4) @(negedge clk);
      block_l  = ~CT1;
      keylen_l = 1'b1;
      next_l   = 1'b1;
      @(negedge clk);
      next_l = 1'b0;
      wait_ready("mid_next");

      // reset at cycle 20 of an AES-256 run
      issue(CT3, KEY3, 1'b1, PT);
      repeat (20) @(negedge clk);
      #2;
      rst_n_l = 1'b0;
      #1;
      check_val(SW, "abort_ready", {127'h0, ready_l}, 128'h1);
      check_val(SW, "abort_new_block", new_block_l, 128'h0);
      q.delete();
      round_bad = 1'b0;
      ign_rise  = 1'b1;
      @(negedge clk);
      rst_n_l = 1'b1;
      @(negedge clk);
      issue(CT1, KEY1, 1'b0, PT);
      wait_ready("after_abort");

      // next held high across two blocks
      wait_ready("b2b_idle");
      ct = {$urandom(), $urandom(), $urandom(), $urandom()};
      load_keys(KEY1, 1'b0);
      block_l  = CT1;
      keylen_l = 1'b0;
      next_l   = 1'b1;
      q.push_back('{PT, 1 + 10 * (S + 1), cyc + 1, 10});
      @(negedge clk);
      block_l = ct;
      check_val(SW, "b2b_busy_first", {127'h0, ready_l}, 128'h0);
      wait_ready("b2b_first");
      q.push_back('{m_decrypt(ct, KEY1, 1'b0), 1 + 10 * (S + 1), cyc + 1, 10});
      @(negedge clk);
      next_l = 1'b0;
      check_val(SW, "b2b_busy_second", {127'h0, ready_l}, 128'h0);
      wait_ready("b2b_second");

      // randomized keys, key lengths and ciphertexts
      for (int i = 0; i < 6; i++) begin
        key = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
        k   = 1'($urandom_range(0, 1));
        ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
        issue(ct, key, k, m_decrypt(ct, key, k));
        wait_ready("random");
      end
      @(negedge clk);
      check_val(SW, "queue_drained", 128'(q.size()), 128'h0);
      lane_done[g] = 1'b1;
    end
  end

  // Build the S-box tables from the field inverse and affine map, then wait.
  initial begin
    logic [7:0] inv;
    logic [7:0] y;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (m_mul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      y = inv ^ m_rotl(inv, 1) ^ m_rotl(inv, 2) ^ m_rotl(inv, 3) ^ m_rotl(inv, 4) ^ 8'h63;
      sbox_t[x]  = y;
      isbox_t[y] = 8'(x);
    end
    tables_ready = 1'b1;
    for (int t = 0; t < 50000 && !(lane_done[0] && lane_done[1] && lane_done[2]); t++)
      @(negedge clk);
    if (!(lane_done[0] && lane_done[1] && lane_done[2])) begin
      checks++;
      failures++;
      $display("FAIL all_lanes_done: got %b%b%b expected 111", lane_done[0], lane_done[1], lane_done[2]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_decipher_block_par.md
# aes_decipher_block_par

Parametrised iterative AES inverse-cipher datapath for AES-128 and AES-256 decryption of one 128-bit block per command. It sits beside the key-expansion memory inside the core. It drives the round index it needs, and the key memory returns the matching round key combinationally. The number of inverse S-box lanes is a parameter, which trades area against latency.

## Interface
- `SBOX_WORDS`, default 1: number of 32-bit words substituted per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `next` in 1: start request, accepted only while `ready`=1.
- `keylen` in 1: 0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14). Captured at acceptance.
- `block` in 128: ciphertext. Captured into the state register at acceptance.
- `round` out 4: registered round-key index requested this cycle.
- `round_key` in 128: key for `round`, valid in the same cycle (combinational from the key memory).
- `new_block` out 128: the state register. It is the plaintext whenever `ready`=1.
- `ready` out 1: 1 = idle, result valid; 0 = busy.

## Operation
- State bytes are column-major, matching FIPS-197: bits [127:96] hold column 0, with the MSB byte in row 0.
- Inverse S-box: `SBOX_WORDS` instances, each 32 bits wide. S = 4/`SBOX_WORDS` substitution cycles per round.
- Word counter `sword_ctr`, 2 bits, advances by `SBOX_WORDS` per SBOX cycle and wraps at 4. Each cycle, words `sword_ctr` .. `sword_ctr`+`SBOX_WORDS`-1 are substituted in place.
- FSM states and transitions:
  - IDLE: `ready`=1. On `next`=1, capture `block` and `keylen`, load `round`=Nr, clear `ready` → INIT.
  - INIT (1 cycle): state ^= `round_key` (key Nr); `round` ← Nr-1; `sword_ctr` ← 0 → SBOX.
  - SBOX (S cycles): substitute words as above. After the cycle that wraps `sword_ctr` → ROUND.
  - ROUND (1 cycle): state ← InvMixColumns(InvShiftRows(state) ^ `round_key`) when `round`≠0.
    - If `round`≠0: decrement `round` → SBOX.
    - If `round`=0: state ← InvShiftRows(state) ^ `round_key`, with no InvMixColumns; set `ready`=1 → IDLE with `round`=0.
  - Order per round is InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns. InvShiftRows and InvSubBytes commute, so substitution before shifting is legal.
- GF(2^8) arithmetic uses the reduction polynomial 0x11b. InvMixColumns uses coefficients {0e,0b,0d,09}.
- `next` while `ready`=0 is ignored and has no effect on the operation in progress.
- `block` and `keylen` may change freely after the acceptance edge.
- `new_block` shows intermediate state while busy. Consumers sample it only when `ready`=1. It holds its value in IDLE until the next acceptance.

## Timing
- Reset values: `ready`=1, `new_block`=0, `round`=0, FSM=IDLE, `sword_ctr`=0.
- Reset is asynchronous. Asserting it mid-operation aborts immediately to the reset values; no partial result is retained.
- Acceptance edge E0 is a rising edge with `next`=1 and `ready`=1. `ready` is 0 from E0.
- `ready` returns to 1 at edge E(1 + Nr·(S+1)):
  - AES-128: 51 cycles (S=4), 31 cycles (S=2), 21 cycles (S=1).
  - AES-256: 71 cycles (S=4), 43 cycles (S=2), 29 cycles (S=1).
- Back-to-back operation: `next` held high at the edge where `ready` rises is not accepted on that edge. The earliest acceptance is the following edge, so there is a minimum of one IDLE cycle between operations.
- `round` changes only on clock edges. The key memory has one full cycle to present `round_key`.

## Test plan
- FIPS-197 C.1, AES-128: key 000102…0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, round keys from the bench model → `new_block`=00112233445566778899aabbccddeeff. `ready` rises exactly 51 cycles after E0 for `SBOX_WORDS`=1; repeat for 2 and 4 (31 and 21 cycles).
- FIPS-197 C.3, AES-256: key 000102…1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 → 00112233445566778899aabbccddeeff. Latency is 71/43/29 cycles for `SBOX_WORDS`=1/2/4.
- `round` sequence check: AES-128 run emits 10 (INIT), then 9,8,…,0. Each value is held for S+1 cycles; `round`=0 once idle.
- `next` pulsed mid-run with a different `block` → result is unchanged and latency is unchanged.
- `reset_n` asserted at cycle 20 of an AES-256 run → `ready`=1 and `new_block`=0 asynchronously. A following C.1 run then decrypts correctly.
- `next` held high continuously for two C.1 blocks → both results are correct, with exactly one IDLE cycle between them.
